// File: rtl/paralelo_serial_tx.sv
// Transmit serializer: bytes in over valid/ready, MSB-first serial out, one bit per clk_32f.
// Empty slots and the post-reset preamble carry the comma byte.
module paralelo_serial_tx #(
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter int unsigned SYNC_BYTES = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       byte_strobe,
    output logic       payload_active,
    output logic       sync_done
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned BIT_W = 3;
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_BYTES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(7);

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] sync_cnt_q, sync_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]       shifter_q, shifter_d;
    logic             hold_valid_q, hold_valid_d;
    logic [7:0]       hold_data_q, hold_data_d;
    logic             payload_q, payload_d;
    logic             strobe_q, strobe_d;

    logic load;
    logic accept;

    assign load      = (bit_cnt_q == BIT_LAST);
    assign ready_out = (state_q == ST_RUN) && (!hold_valid_q || load);
    assign accept    = valid_in && ready_out;

    // Next-state: shifter/slot sequencing plus the single-entry holding register
    always_comb begin
        state_d      = state_q;
        sync_cnt_d   = sync_cnt_q;
        bit_cnt_d    = bit_cnt_q + BIT_W'(1);
        shifter_d    = {shifter_q[6:0], 1'b0};
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        payload_d    = payload_q;
        strobe_d     = load;

        if (load) begin
            bit_cnt_d = '0;
            if (state_q == ST_SYNC) begin
                shifter_d  = COMMA;
                payload_d  = 1'b0;
                sync_cnt_d = sync_cnt_q + CNT_W'(1);
                if (sync_cnt_q == SYNC_LAST) begin
                    state_d = ST_RUN;
                end
            end else if (hold_valid_q) begin
                shifter_d = hold_data_q;
                payload_d = 1'b1;
            end else begin
                shifter_d = COMMA;
                payload_d = 1'b0;
            end
        end

        // Accept on a load refills the hold while the old byte moves to the shifter
        if (accept) begin
            hold_data_d  = data_in;
            hold_valid_d = 1'b1;
        end else if (load && hold_valid_q) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            state_q      <= ST_SYNC;
            sync_cnt_q   <= '0;
            bit_cnt_q    <= BIT_LAST;
            shifter_q    <= 8'h00;
            hold_valid_q <= 1'b0;
            hold_data_q  <= 8'h00;
            payload_q    <= 1'b0;
            strobe_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_cnt_q   <= sync_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shifter_q    <= shifter_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            payload_q    <= payload_d;
            strobe_q     <= strobe_d;
        end
    end

    assign data_out       = shifter_q[7];
    assign byte_strobe    = strobe_q;
    assign payload_active = payload_q;
    assign sync_done      = (state_q == ST_RUN);

endmodule
